// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, instruction field positions and jump helper for cpu_ctrl
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_EXEC,
        S_MEM_WR
    } state_t;

    // Instruction field bit positions (Hack encoding: 111a cccc ccdd djjj)
    localparam int IS_C    = 15;
    localparam int ABIT    = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int J_LT    = 2;
    localparam int J_EQ    = 1;
    localparam int J_GT    = 0;

    // Jump resolution from the ALU flags; 3'b111 covers all three cases so it always jumps
    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & ~zr & ~ng);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - Hack-style combinational ALU with zx/nx/zy/ny/f/no controls
module alu #(
    parameter int WORDSIZE = 16
) (
    input  logic [WORDSIZE-1:0] x,
    input  logic [WORDSIZE-1:0] y,
    input  logic                zx,
    input  logic                nx,
    input  logic                zy,
    input  logic                ny,
    input  logic                f,
    input  logic                no,
    output logic [WORDSIZE-1:0] out,
    output logic                zr,
    output logic                ng
);

    logic [WORDSIZE-1:0] xz;
    logic [WORDSIZE-1:0] xn;
    logic [WORDSIZE-1:0] yz;
    logic [WORDSIZE-1:0] yn;
    logic [WORDSIZE-1:0] fo;

    // Operand conditioning, function select, output negate and flags
    always_comb begin
        xz  = zx ? '0 : x;
        xn  = nx ? ~xz : xz;
        yz  = zy ? '0 : y;
        yn  = ny ? ~yz : yz;
        fo  = f ? (xn + yn) : (xn & yn);
        out = no ? ~fo : fo;
        zr  = (out == '0);
        ng  = out[WORDSIZE-1];
    end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle Hack CPU sequencer: fetch, decode, M read, execute, M write
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int WORDSIZE = 16,
    parameter int ADDRW    = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                instr_req,
    output logic [ADDRW-1:0]    instr_addr,
    input  logic                instr_valid,
    input  logic [WORDSIZE-1:0] instr_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDRW-1:0]    mem_addr,
    output logic [WORDSIZE-1:0] mem_wdata,
    input  logic [WORDSIZE-1:0] mem_rdata,
    input  logic                mem_valid,
    output logic [ADDRW-1:0]    pc,
    output logic [WORDSIZE-1:0] a_reg,
    output logic [WORDSIZE-1:0] d_reg,
    output logic                busy
);

    localparam logic [ADDRW-1:0] PC_ONE = ADDRW'(1);

    state_t              state;
    logic [WORDSIZE-1:0] ir;
    logic [WORDSIZE-1:0] m_latch;
    logic [WORDSIZE-1:0] alu_y;
    logic [WORDSIZE-1:0] alu_out;
    logic                alu_zr;
    logic                alu_ng;
    logic [ADDRW-1:0]    pc_inc;
    logic                take_jump;

    // The fetch request follows run live so a stopped CPU issues nothing new
    assign instr_req  = (state == S_FETCH) && run;
    assign instr_addr = pc;
    assign pc_inc     = pc + PC_ONE;
    assign alu_y      = ir[ABIT] ? m_latch : a_reg;
    assign take_jump  = jump_taken(ir[J_LT:J_GT], alu_zr, alu_ng);

    alu #(
        .WORDSIZE(WORDSIZE)
    ) u_alu (
        .x  (d_reg),
        .y  (alu_y),
        .zx (ir[COMP_HI]),
        .nx (ir[COMP_HI-1]),
        .zy (ir[COMP_HI-2]),
        .ny (ir[COMP_HI-3]),
        .f  (ir[COMP_LO+1]),
        .no (ir[COMP_LO]),
        .out(alu_out),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    // Sequencer: state, architectural registers and registered memory-side outputs.
    // Right-hand sides read a_reg before the update, so the M write address is always A_old.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= '0;
            a_reg     <= '0;
            d_reg     <= '0;
            ir        <= '0;
            m_latch   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_req && instr_valid) begin
                        ir    <= instr_data;
                        state <= S_DECODE;
                        busy  <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!ir[IS_C]) begin
                        a_reg <= ir;
                        pc    <= pc_inc;
                        state <= S_FETCH;
                        busy  <= 1'b0;
                    end else if (ir[ABIT]) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= a_reg[ADDRW-1:0];
                        state    <= S_MEM_RD;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_MEM_RD: begin
                    if (mem_valid) begin
                        m_latch <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ir[DEST_A]) begin
                        a_reg <= alu_out;
                    end
                    if (ir[DEST_D]) begin
                        d_reg <= alu_out;
                    end
                    pc <= take_jump ? a_reg[ADDRW-1:0] : pc_inc;
                    if (ir[DEST_M]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= a_reg[ADDRW-1:0];
                        mem_wdata <= alu_out;
                        state     <= S_MEM_WR;
                    end else begin
                        state <= S_FETCH;
                        busy  <= 1'b0;
                    end
                end
                S_MEM_WR: begin
                    if (mem_valid) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_FETCH;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_FETCH;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
